// File: rtl/ahblite_qn8027_i2c_ctrl_if.sv
// AHB-Lite slave port bundle for the QN8027 I2C write controller.
interface ahblite_qn8027_i2c_ctrl_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/ahblite_qn8027_i2c_ctrl.sv
// AHB-Lite slave that issues complete 3-byte I2C register writes to a QN8027:
// START, {DEV_ADDR,W}, reg_addr, data, STOP, checking ACK after each byte.
module ahblite_qn8027_i2c_ctrl #(
  parameter logic [6:0]  DEV_ADDR  = 7'h2C,
  parameter logic [15:0] DIV_RESET = 16'd124
) (
  input  logic                            HCLK,
  input  logic                            HRESETn,
  ahblite_qn8027_i2c_ctrl_if.slave        ahb,
  output logic                            QN_IIC_SCL,
  inout  wire                             QN_IIC_SDA
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP} state_t;

  state_t      state, state_n;
  logic [1:0]  phase, phase_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [1:0]  byte_idx, byte_idx_n;
  logic [23:0] shift, shift_n;
  logic        ack_fail, ack_fail_n;
  logic [15:0] qcnt, div_q, cmd_q;
  logic        ap_sel, ap_write;
  logic [1:0]  ap_addr;
  logic        done_q, nack_q, ovr_q;
  logic [1:0]  sda_sync;
  logic        scl_q, sda_oe_q, scl_n, sda_oe_n;
  logic        tick, busy, idle_next, wr_en, cmd_wr, cmd_accept, st_wr;
  logic        done_set, nack_set;
  logic [31:0] rdata;
  logic        unused_bits;

  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;
  assign ahb.HRDATA    = rdata;
  assign unused_bits   = ^{ahb.HSIZE, ahb.HPROT, ahb.HTRANS[0], ahb.HADDR[31:4],
                           ahb.HADDR[1:0], ahb.HWDATA[31:16]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_sel   <= 1'b0;
      ap_write <= 1'b0;
      ap_addr  <= 2'd0;
    end else if (ahb.HREADY) begin
      ap_sel   <= ahb.HSEL & ahb.HTRANS[1];
      ap_write <= ahb.HWRITE;
      ap_addr  <= ahb.HADDR[3:2];
    end
  end

  assign busy       = (state != S_IDLE);
  assign tick       = busy && (qcnt == div_q);
  // The final STOP tick counts as idle so a command can chain without a gap.
  assign idle_next  = !busy || (state == S_STOP && phase == 2'd2 && tick);
  assign wr_en      = ap_sel & ap_write;
  assign cmd_wr     = wr_en && (ap_addr == 2'd0);
  assign cmd_accept = cmd_wr && idle_next;
  assign st_wr      = wr_en && (ap_addr == 2'd1);

  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    state_n    = state;
    phase_n    = phase;
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    shift_n    = shift;
    ack_fail_n = ack_fail;
    done_set   = 1'b0;
    nack_set   = 1'b0;
    if (tick) begin
      phase_n = phase + 2'd1;
      case (state)
        S_START: if (phase == 2'd1) begin
          state_n   = S_BIT;
          phase_n   = 2'd0;
          bit_idx_n = 3'd0;
        end
        S_BIT: if (phase == 2'd3) begin
          shift_n   = {shift[22:0], 1'b0};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = S_ACK;
        end
        S_ACK: begin
          if (phase == 2'd2 && sda_sync[1]) begin
            ack_fail_n = 1'b1;
            nack_set   = 1'b1;
          end
          if (phase == 2'd3) begin
            if (ack_fail || byte_idx == 2'd2) state_n = S_STOP;
            else begin
              state_n    = S_BIT;
              byte_idx_n = byte_idx + 2'd1;
            end
          end
        end
        S_STOP: if (phase == 2'd2) begin
          state_n  = S_IDLE;
          phase_n  = 2'd0;
          done_set = 1'b1;
        end
        default: ;
      endcase
    end
    if (cmd_accept) begin
      state_n    = S_START;
      phase_n    = 2'd0;
      bit_idx_n  = 3'd0;
      byte_idx_n = 2'd0;
      shift_n    = {DEV_ADDR, 1'b0, ahb.HWDATA[15:0]};
      ack_fail_n = 1'b0;
    end
  end

  // Pin levels are decoded from the next state and registered, so the pins never glitch.
  always_comb begin
    scl_n    = 1'b1;
    sda_oe_n = 1'b0;
    case (state_n)
      S_START: begin
        scl_n    = (phase_n == 2'd0);
        sda_oe_n = 1'b1;
      end
      S_BIT: begin
        scl_n    = (phase_n == 2'd1) || (phase_n == 2'd2);
        sda_oe_n = ~shift_n[23];
      end
      S_ACK:  scl_n = (phase_n == 2'd1) || (phase_n == 2'd2);
      S_STOP: begin
        scl_n    = (phase_n != 2'd0);
        sda_oe_n = (phase_n != 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= S_IDLE;
      phase    <= 2'd0;
      bit_idx  <= 3'd0;
      byte_idx <= 2'd0;
      shift    <= 24'd0;
      ack_fail <= 1'b0;
      qcnt     <= 16'd0;
      scl_q    <= 1'b1;
      sda_oe_q <= 1'b0;
      sda_sync <= 2'b11;
      cmd_q    <= 16'd0;
      div_q    <= DIV_RESET;
      done_q   <= 1'b0;
      nack_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      bit_idx  <= bit_idx_n;
      byte_idx <= byte_idx_n;
      shift    <= shift_n;
      ack_fail <= ack_fail_n;
      qcnt     <= (!busy || tick) ? 16'd0 : qcnt + 16'd1;
      scl_q    <= scl_n;
      sda_oe_q <= sda_oe_n;
      sda_sync <= {sda_sync[0], QN_IIC_SDA};
      if (cmd_accept) cmd_q <= ahb.HWDATA[15:0];
      if (wr_en && ap_addr == 2'd2 && !busy) div_q <= ahb.HWDATA[15:0];
      // Same-cycle set beats any clear.
      done_q   <= done_set | (done_q & ~cmd_accept & ~(st_wr & ahb.HWDATA[1]));
      nack_q   <= nack_set | (nack_q & ~(st_wr & ahb.HWDATA[2]));
      ovr_q    <= (cmd_wr & ~idle_next) | (ovr_q & ~(st_wr & ahb.HWDATA[3]));
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (ap_addr)
      2'd0:    rdata = {16'd0, cmd_q};
      2'd1:    rdata = {28'd0, ovr_q, nack_q, done_q, busy};
      2'd2:    rdata = {16'd0, div_q};
      default: rdata = 32'd0;
    endcase
  end

  assign QN_IIC_SCL = scl_q;
  assign QN_IIC_SDA = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ahblite_qn8027_i2c_ctrl.sv
// Directed bench: AHB-Lite master tasks plus a passive I2C slave that decodes bytes and ACKs/NACKs.
module tb_ahblite_qn8027_i2c_ctrl;

  logic HCLK;
  logic HRESETn;
  logic scl;
  wire  sda_bus;
  logic slave_drive;

  ahblite_qn8027_i2c_ctrl_if bus ();

  ahblite_qn8027_i2c_ctrl dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .ahb        (bus),
    .QN_IIC_SCL (scl),
    .QN_IIC_SDA (sda_bus)
  );

  pullup (sda_bus);
  assign sda_bus = slave_drive ? 1'b0 : 1'bz;

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Passive slave / bus monitor, sampled mid-cycle.
  logic [7:0] bytes_q[$];
  logic [7:0] shreg;
  int  start_cnt, stop_cnt, bit_cnt, byte_cnt, nack_byte;
  bit  in_frame, ack_phase, prev_scl, prev_sda;

  always @(negedge HCLK) begin
    if (!HRESETn) begin
      slave_drive = 1'b0;
      in_frame    = 1'b0;
      ack_phase   = 1'b0;
    end else if (scl && prev_scl && prev_sda && !sda_bus) begin
      start_cnt++;
      bit_cnt   = 0;
      byte_cnt  = 0;
      ack_phase = 1'b0;
      in_frame  = 1'b1;
    end else if (scl && prev_scl && !prev_sda && sda_bus) begin
      stop_cnt++;
      in_frame = 1'b0;
    end else if (in_frame && scl && !prev_scl) begin
      if (bit_cnt < 8) begin
        shreg = {shreg[6:0], sda_bus};
        bit_cnt++;
      end
    end else if (in_frame && !scl && prev_scl) begin
      if (ack_phase) begin
        slave_drive = 1'b0;
        ack_phase   = 1'b0;
        bit_cnt     = 0;
        byte_cnt++;
      end else if (bit_cnt == 8) begin
        bytes_q.push_back(shreg);
        ack_phase   = 1'b1;
        slave_drive = (byte_cnt != nack_byte);
      end
    end
    prev_scl = scl;
    prev_sda = sda_bus;
  end

  task automatic clear_mon(input int nack_at);
    bytes_q.delete();
    start_cnt = 0;
    stop_cnt  = 0;
    nack_byte = nack_at;
  endtask

  task automatic check_frame(input string tag, input logic [7:0] exp[$], input int n_frames);
    check({tag, "_nbytes"}, bytes_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < bytes_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), {24'd0, bytes_q[i]}, {24'd0, exp[i]});
    check({tag, "_starts"}, start_cnt, n_frames);
    check({tag, "_stops"}, stop_cnt, n_frames);
  endtask

  task automatic bus_idle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HADDR  = 32'd0;
  endtask

  task automatic drive_addr(input bit wr, input logic [31:0] a);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HWRITE = wr;
    bus.HADDR  = a;
    bus.HSIZE  = 3'b010;
    bus.HPROT  = 4'h3;
    bus.HREADY = 1'b1;
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge HCLK); #1;
    drive_addr(1'b1, a);
    @(posedge HCLK); #1;
    bus_idle();
    bus.HWDATA = d;
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    @(posedge HCLK); #1;
    drive_addr(1'b0, a);
    @(posedge HCLK); #1;
    bus_idle();
    @(negedge HCLK);
    d = bus.HRDATA;
  endtask

  // Writes CMD then polls STATUS every cycle. Cycle 1 is the first busy cycle.
  // Optional: one write whose data phase lands in cycle inj_cyc, a STATUS probe at
  // probe_cyc, and a reset assertion at rst_cyc (which ends the run).
  task automatic run_txn(input logic [15:0] cmd, input int inj_cyc, input logic [31:0] inj_addr,
                         input logic [31:0] inj_data, input int probe_cyc, input int rst_cyc,
                         output int busy_len, output logic [31:0] probe_st,
                         output logic [31:0] end_st);
    int k;
    bit fin, rd_valid, pend;
    busy_len = -1;
    probe_st = '0;
    end_st   = '0;
    @(posedge HCLK); #1;
    drive_addr(1'b1, 32'h0);
    @(posedge HCLK); #1;
    bus.HWDATA = {16'd0, cmd};
    drive_addr(1'b0, 32'h4);
    k    = 0;
    fin  = 1'b0;
    pend = 1'b0;
    while (!fin && k < 20000) begin
      @(posedge HCLK); #1;
      k++;
      rd_valid = !pend;
      if (pend) begin
        bus.HWDATA = inj_data;
        drive_addr(1'b0, 32'h4);
        pend = 1'b0;
      end
      @(negedge HCLK);
      if (k == rst_cyc) begin
        check("scl_before_reset", {31'd0, scl}, 32'd0);
        HRESETn = 1'b0;
        #1;
        check("reset_scl_high", {31'd0, scl}, 32'd1);
        check("reset_sda_released", {31'd0, sda_bus}, 32'd1);
        busy_len = k;
        fin = 1'b1;
      end else begin
        if (rd_valid) begin
          if (k == probe_cyc) probe_st = bus.HRDATA;
          if (!bus.HRDATA[0]) begin
            busy_len = k - 1;
            end_st   = bus.HRDATA;
            fin      = 1'b1;
          end
        end
        if (!fin && k + 1 == inj_cyc) begin
          drive_addr(1'b1, inj_addr);
          pend = 1'b1;
        end
      end
    end
    if (!fin) check("busy_timeout", 32'd1, 32'd0);
    bus_idle();
  endtask

  logic [31:0] rd, probe_st, end_st;
  int busy_len;
  logic [7:0] exp_q[$];

  initial begin
    HRESETn     = 1'b0;
    slave_drive = 1'b0;
    bus_idle();
    bus.HSIZE  = 3'b010;
    bus.HPROT  = 4'h3;
    bus.HREADY = 1'b1;
    bus.HWDATA = 32'd0;
    clear_mon(-1);
    repeat (3) @(negedge HCLK);
    check("reset_scl", {31'd0, scl}, 32'd1);
    check("reset_sda", {31'd0, sda_bus}, 32'd1);
    HRESETn = 1'b1;

    ahb_read(32'h4, rd); check("reset_status", rd, 32'h0);
    ahb_read(32'h8, rd); check("reset_div", rd, 32'd124);
    ahb_read(32'h0, rd); check("reset_cmd", rd, 32'h0);
    ahb_read(32'hC, rd); check("reg3_reads_zero", rd, 32'h0);

    // Normal transaction, DIV=0.
    ahb_write(32'h8, 32'd0);
    clear_mon(-1);
    run_txn(16'h105A, 0, 0, 0, 50, 0, busy_len, probe_st, end_st);
    check("ok_busy_len", busy_len, 32'd113);
    check("ok_probe_status", probe_st, 32'h1);
    check("ok_end_status", end_st, 32'h2);
    exp_q = '{8'h58, 8'h10, 8'h5A};
    check_frame("ok", exp_q, 1);
    ahb_read(32'h0, rd); check("ok_cmd_readback", rd, 32'h105A);

    // Address NACK, DIV=3.
    ahb_write(32'h8, 32'd3);
    clear_mon(0);
    run_txn(16'h105A, 0, 0, 0, 0, 0, busy_len, probe_st, end_st);
    check("nack_busy_len", busy_len, 32'd164);
    check("nack_end_status", end_st, 32'h6);
    exp_q = '{8'h58};
    check_frame("nack", exp_q, 1);
    ahb_write(32'h4, 32'hE);

    // CMD write while busy sets OVR and leaves the transfer intact.
    ahb_write(32'h8, 32'd0);
    clear_mon(-1);
    run_txn(16'h105A, 30, 32'h0, 32'h7777, 0, 0, busy_len, probe_st, end_st);
    check("ovr_busy_len", busy_len, 32'd113);
    check("ovr_end_status", end_st, 32'hA);
    exp_q = '{8'h58, 8'h10, 8'h5A};
    check_frame("ovr", exp_q, 1);
    ahb_read(32'h0, rd); check("ovr_cmd_kept", rd, 32'h105A);
    ahb_write(32'h4, 32'hE);
    ahb_read(32'h4, rd); check("w1c_clear_all", rd, 32'h0);

    // DIV write while busy is ignored.
    clear_mon(-1);
    run_txn(16'h4321, 40, 32'h8, 32'h55, 0, 0, busy_len, probe_st, end_st);
    check("divbusy_busy_len", busy_len, 32'd113);
    check("divbusy_end_status", end_st, 32'h2);
    ahb_read(32'h8, rd); check("divbusy_div_kept", rd, 32'h0);

    // W1C of DONE in the cycle DONE is set: set wins.
    clear_mon(-1);
    run_txn(16'h105A, 113, 32'h4, 32'hE, 0, 0, busy_len, probe_st, end_st);
    check("w1c_race_busy_len", busy_len, 32'd113);
    check("w1c_race_status", end_st, 32'h2);

    // Back-to-back: second CMD lands in the last busy cycle.
    clear_mon(-1);
    run_txn(16'h105A, 113, 32'h0, 32'h2233, 150, 0, busy_len, probe_st, end_st);
    check("b2b_busy_len", busy_len, 32'd226);
    check("b2b_first_done", probe_st, 32'h3);
    check("b2b_end_status", end_st, 32'h2);
    exp_q = '{8'h58, 8'h10, 8'h5A, 8'h58, 8'h22, 8'h33};
    check_frame("b2b", exp_q, 2);

    // Reset in quarter 50 aborts without STOP.
    clear_mon(-1);
    run_txn(16'h105A, 0, 0, 0, 0, 51, busy_len, probe_st, end_st);
    check("abort_no_stop", stop_cnt, 32'd0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    ahb_read(32'h4, rd); check("abort_status", rd, 32'h0);
    ahb_read(32'h8, rd); check("abort_div", rd, 32'd124);
    ahb_write(32'h8, 32'd0);
    clear_mon(-1);
    run_txn(16'h0A5F, 0, 0, 0, 0, 0, busy_len, probe_st, end_st);
    check("after_abort_busy_len", busy_len, 32'd113);
    check("after_abort_status", end_st, 32'h2);
    exp_q = '{8'h58, 8'h0A, 8'h5F};
    check_frame("after_abort", exp_q, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
